gb_scaler: RTL and testbench
============================

GB_SCALER -- requirements
Module: gb_scaler

Parameters
REQ-001 H_ACTIVE 800, H_FP 88, H_SYNC 128, H_BP 40: horizontal timing in clocks.
REQ-002 V_ACTIVE 480, V_FP 21, V_SYNC 3, V_BP 1: vertical timing in lines.
REQ-003 SRC_W 160, SRC_H 144: source framebuffer size in pixels.
REQ-004 SCALE 3: integer upscale factor, at least 1.
REQ-005 RD_LAT 1: framebuffer read latency in clocks, at least 1.
REQ-006 ADDR_W 15: framebuffer address width.
REQ-007 BORDER 16'h0000: RGB565 colour outside the picture window.
REQ-008 Elaboration SHALL fail if SRC_W*SCALE > H_ACTIVE, SRC_H*SCALE > V_ACTIVE, or SRC_W*SRC_H > 2^ADDR_W.

Interface
REQ-009 clk  in  1  single clock for the whole block.
REQ-010 rst  in  1  asynchronous, active-low reset.
REQ-011 fb_addr  out  ADDR_W  framebuffer read address.
REQ-012 fb_data  in  2  pixel index, valid RD_LAT clocks after fb_addr.
REQ-013 pal_we  in  1  palette write strobe.
REQ-014 pal_idx  in  2  palette entry to write.
REQ-015 pal_rgb  in  16  RGB565 value to write.
REQ-016 hs, vs  out  1  syncs, active-low.
REQ-017 de  out  1  display enable.
REQ-018 r, b  out  5 each;  g  out  6  pixel colour.
REQ-019 frame_start  out  1  one-clock pulse aligned with the first de of each frame.

Function
REQ-020 The h counter SHALL run 0..H_TOTAL-1, where H_TOTAL is the sum of the four H_ terms, and wrap to 0.
REQ-021 The v counter SHALL run 0..V_TOTAL-1 and SHALL advance only on h wrap.
REQ-022 Line order SHALL be ACTIVE, FP, SYNC, BP; active when h<H_ACTIVE; hs low when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC. Vertical timing SHALL use the same rule in lines.
REQ-023 Window offsets SHALL be OFF_X=(H_ACTIVE-SRC_W*SCALE)/2 and OFF_Y=(V_ACTIVE-SRC_H*SCALE)/2, rounded down.
REQ-024 in_win SHALL be set when OFF_X <= h < OFF_X+SRC_W*SCALE and OFF_Y <= v < OFF_Y+SRC_H*SCALE.
REQ-025 Address generation SHALL be incremental (no multiplier):
- sx increments once every SCALE in-window clocks.
- line base advances by SRC_W after every SCALE in-window lines.
- fb_addr = base+sx.
- base resets to 0 at v wrap.
- sx resets to 0 at the start of each line.
REQ-026 fb_addr SHALL hold its last value outside the window.
REQ-027 Pixel pipeline: hs, vs, de, in_win and frame_start SHALL be delayed RD_LAT clocks to align with fb_data, then registered once more. Output latency from counter state to pins SHALL therefore be RD_LAT+1 clocks for every output.
REQ-028 Colour: in_win and de → palette[fb_data]; de without in_win → BORDER; no de → 0.
REQ-029 Palette SHALL be 4×16-bit registers; a write SHALL take effect on the clock edge.
REQ-030 A lookup in the same clock as a write to the same index SHALL return the old value.
REQ-031 Mid-frame palette writes SHALL be allowed; no tearing protection is provided.
REQ-032 frame_start SHALL fire when h=0, v=0, before delay.

Reset
REQ-033 Reset asserted SHALL asynchronously force:
- h=v=0, sx=base=0, fb_addr=0.
- all pipeline stages cleared.
- hs=vs=1, de=0, r=g=b=0, frame_start=0.
REQ-034 Palette reset values: 0:0x0000, 1:0x4208, 2:0x8410, 3:0xFFFF.
REQ-035 After reset release, the first frame_start SHALL occur RD_LAT+1 clocks after the first clk edge.
REQ-036 Reset asserted mid-line SHALL abort the frame; the next frame restarts cleanly at h=v=0.

Verification
Small configuration for all scenarios: H 16/2/3/3, V 8/1/2/1, SRC 4×2, SCALE 2, RD_LAT 1 (OFF_X=4, OFF_Y=2, H_TOTAL=24, V_TOTAL=12).
REQ-037 Timing: free run 2 frames → period 288 clocks; hs low 3 clocks per line starting at h=18 (pin time h+2); vs low for lines 9–10; de high 16 clocks on lines 0–7.
REQ-038 Addressing: on line v=2, fb_addr = 0,0,1,1,2,2,3,3 for h=4..11; lines 4–5 use base 4 → addresses 4..7; v=6 line → window exited, fb_addr holds 7.
REQ-039 Palette mapping: model returns fb_data=addr[1:0]. Window pixels → 0x0000, 0x4208, 0x8410, 0xFFFF repeating every 2 pixels; de pixels outside the window → BORDER; blanking → 0.
REQ-040 Palette write collision: pal_we with idx 3, rgb 0xF800, in the same clock as a lookup of idx 3 → that pixel shows 0xFFFF; subsequent idx-3 pixels show 0xF800.
REQ-041 Reset mid-line: assert rst at h=7, v=3 for 2 clocks → outputs immediately at reset values; after release, frame_start follows 2 clocks later and fb_addr sequence restarts from 0.
REQ-042 Latency sweep: rerun REQ-038 and REQ-039 with RD_LAT=3 → all outputs shift by 2 further clocks; colours remain correctly aligned.

Source files
------------

// File: rtl/gb_scaler_if.sv
// Scaler bus: framebuffer read port, palette write port, video pins.
// master is the scaler side; slave is the framebuffer/display side.
interface gb_scaler_if #(
    parameter int ADDR_W = 15
);
    logic [ADDR_W-1:0] fb_addr;
    logic [1:0]        fb_data;
    logic              pal_we;
    logic [1:0]        pal_idx;
    logic [15:0]       pal_rgb;
    logic              hs;
    logic              vs;
    logic              de;
    logic [4:0]        r;
    logic [5:0]        g;
    logic [4:0]        b;
    logic              frame_start;

    modport master (
        output fb_addr, hs, vs, de, r, g, b, frame_start,
        input  fb_data, pal_we, pal_idx, pal_rgb
    );

    modport slave (
        input  fb_addr, hs, vs, de, r, g, b, frame_start,
        output fb_data, pal_we, pal_idx, pal_rgb
    );
endinterface

// File: rtl/gb_scaler.sv
// Integer upscaler from a 2-bit indexed framebuffer to RGB565 video.
// Raster timing, incremental address walk, palette and output pipeline.
module gb_scaler #(
    parameter int          H_ACTIVE = 800,
    parameter int          H_FP     = 88,
    parameter int          H_SYNC   = 128,
    parameter int          H_BP     = 40,
    parameter int          V_ACTIVE = 480,
    parameter int          V_FP     = 21,
    parameter int          V_SYNC   = 3,
    parameter int          V_BP     = 1,
    parameter int          SRC_W    = 160,
    parameter int          SRC_H    = 144,
    parameter int          SCALE    = 3,
    parameter int          RD_LAT   = 1,
    parameter int          ADDR_W   = 15,
    parameter logic [15:0] BORDER   = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    gb_scaler_if.master bus
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int WIN_W   = SRC_W * SCALE;
    localparam int WIN_H   = SRC_H * SCALE;
    localparam int OFF_X   = (H_ACTIVE - WIN_W) / 2;
    localparam int OFF_Y   = (V_ACTIVE - WIN_H) / 2;
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);
    localparam int SXW     = $clog2(SRC_W + 1);
    localparam int CW      = $clog2(SCALE + 1);

    localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT   = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END  = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] WX_BEG  = HW'(OFF_X);
    localparam logic [HW-1:0] WX_END  = HW'(OFF_X + WIN_W);
    localparam logic [HW-1:0] WX_LAST = HW'(OFF_X + WIN_W - 1);

    localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT   = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END  = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] WY_BEG  = VW'(OFF_Y);
    localparam logic [VW-1:0] WY_END  = VW'(OFF_Y + WIN_H);

    localparam logic [CW-1:0]     C_LAST   = CW'(SCALE - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(SRC_W);

    if (SCALE < 1) begin : g_bad_scale
        $error("gb_scaler: SCALE must be at least 1");
    end
    if (RD_LAT < 1) begin : g_bad_lat
        $error("gb_scaler: RD_LAT must be at least 1");
    end
    if (SRC_W * SCALE > H_ACTIVE) begin : g_bad_w
        $error("gb_scaler: SRC_W*SCALE exceeds H_ACTIVE");
    end
    if (SRC_H * SCALE > V_ACTIVE) begin : g_bad_h
        $error("gb_scaler: SRC_H*SCALE exceeds V_ACTIVE");
    end
    if (longint'(SRC_W) * longint'(SRC_H) > (longint'(1) << ADDR_W)) begin : g_bad_a
        $error("gb_scaler: framebuffer does not fit ADDR_W");
    end

    logic [HW-1:0]            h;
    logic [VW-1:0]            v;
    logic [SXW-1:0]           sx;
    logic [CW-1:0]            cx;
    logic [CW-1:0]            cy;
    logic [ADDR_W-1:0]        base;
    logic [ADDR_W-1:0]        addr_hold;
    logic [ADDR_W-1:0]        addr_c;
    logic                     h_wrap;
    logic                     v_wrap;
    logic                     de_c;
    logic                     hs_c;
    logic                     vs_c;
    logic                     fs_c;
    logic                     in_win;
    logic [RD_LAT-1:0][4:0]   pipe;
    logic [4:0]               al;
    logic [15:0]              pal [4];
    logic [15:0]              rgb;

    assign h_wrap = (h == H_LAST);
    assign v_wrap = (v == V_LAST);
    assign de_c   = (h < H_ACT) && (v < V_ACT);
    assign hs_c   = (h >= HS_BEG) && (h < HS_END);
    assign vs_c   = (v >= VS_BEG) && (v < VS_END);
    assign fs_c   = (h == '0) && (v == '0);
    assign in_win = (h >= WX_BEG) && (h < WX_END)
                 && (v >= WY_BEG) && (v < WY_END);

    // Outside the window the last in-window address is presented.
    assign addr_c      = base + ADDR_W'(sx);
    assign bus.fb_addr = in_win ? addr_c : addr_hold;

    // Raster position: h every clock, v on h wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h <= '0;
            v <= '0;
        end else if (h_wrap) begin
            h <= '0;
            v <= v_wrap ? '0 : v + 1'b1;
        end else begin
            h <= h + 1'b1;
        end
    end

    // Walk sx/base through the window; sx restarts each line, base each frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sx        <= '0;
            cx        <= '0;
            cy        <= '0;
            base      <= '0;
            addr_hold <= '0;
        end else begin
            if (in_win) begin
                addr_hold <= addr_c;
            end
            if (h_wrap) begin
                sx <= '0;
                cx <= '0;
            end else if (in_win) begin
                if (cx == C_LAST) begin
                    cx <= '0;
                    sx <= sx + 1'b1;
                end else begin
                    cx <= cx + 1'b1;
                end
            end
            if (h_wrap && v_wrap) begin
                base <= '0;
                cy   <= '0;
            end else if (in_win && (h == WX_LAST)) begin
                if (cy == C_LAST) begin
                    cy   <= '0;
                    base <= base + ROW_STEP;
                end else begin
                    cy <= cy + 1'b1;
                end
            end
        end
    end

    // Delay raster controls by the read latency so they meet fb_data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe <= '0;
        end else begin
            pipe[0] <= {fs_c, in_win, de_c, vs_c, hs_c};
            for (int i = 1; i < RD_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign al = pipe[RD_LAT-1];

    // Palette: a write lands on the edge, so a same-cycle lookup sees the old entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pal[0] <= 16'h0000;
            pal[1] <= 16'h4208;
            pal[2] <= 16'h8410;
            pal[3] <= 16'hFFFF;
        end else if (bus.pal_we) begin
            pal[bus.pal_idx] <= bus.pal_rgb;
        end
    end

    // Pick picture, border or blank colour for the aligned pixel.
    always_comb begin
        rgb = 16'h0000;
        if (al[2]) begin
            rgb = al[3] ? pal[bus.fb_data] : BORDER;
        end
    end

    // Output pins, one register after the aligned data; syncs are active-low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.hs          <= 1'b1;
            bus.vs          <= 1'b1;
            bus.de          <= 1'b0;
            bus.frame_start <= 1'b0;
            bus.r           <= '0;
            bus.g           <= '0;
            bus.b           <= '0;
        end else begin
            bus.hs          <= ~al[0];
            bus.vs          <= ~al[1];
            bus.de          <= al[2];
            bus.frame_start <= al[4];
            {bus.r, bus.g, bus.b} <= rgb;
        end
    end

endmodule

// File: tb/tb_gb_scaler.sv
// Directed bench for gb_scaler in the small configuration.
// Two instances: read latency 1 and read latency 3.
module tb_gb_scaler;

    localparam int          FR  = 288;
    localparam logic [15:0] BRD = 16'h07E0;

    logic clk = 1'b0;
    logic rst;
    int   vecs = 0;
    int   errs = 0;
    int   k    = 0;

    int hs_lo  = 0;
    int vs_lo  = 0;
    int de_hi  = 0;
    int fs_cnt = 0;
    int fs_a   = -1;
    int fs_b   = -1;
    int fs3    = -1;

    int          adr_tab [8] = '{0, 0, 1, 1, 2, 2, 3, 3};
    logic [15:0] col_tab [8] = '{16'h0000, 16'h0000, 16'h4208, 16'h4208,
                                 16'h8410, 16'h8410, 16'hFFFF, 16'hFFFF};

    always #5 clk = ~clk;

    gb_scaler_if #(.ADDR_W(15)) b1 ();
    gb_scaler_if #(.ADDR_W(15)) b3 ();

    gb_scaler #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SRC_W(4), .SRC_H(2), .SCALE(2), .RD_LAT(1),
        .ADDR_W(15), .BORDER(BRD)
    ) u1 (
        .clk(clk),
        .rst(rst),
        .bus(b1)
    );

    gb_scaler #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SRC_W(4), .SRC_H(2), .SCALE(2), .RD_LAT(3),
        .ADDR_W(15), .BORDER(BRD)
    ) u3 (
        .clk(clk),
        .rst(rst),
        .bus(b3)
    );

    // Framebuffer models: pixel index = addr[1:0], RD_LAT clocks later.
    logic [1:0] d1 = 2'd0;
    logic [1:0] d3 [3] = '{2'd0, 2'd0, 2'd0};

    always @(posedge clk) begin
        d1    <= b1.fb_addr[1:0];
        d3[0] <= b3.fb_addr[1:0];
        d3[1] <= d3[0];
        d3[2] <= d3[1];
    end

    assign b1.fb_data = d1;
    assign b3.fb_data = d3[2];

    function automatic logic [15:0] rgb1();
        return {b1.r, b1.g, b1.b};
    endfunction

    function automatic logic [15:0] rgb3();
        return {b3.r, b3.g, b3.b};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        k++;
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, " hs1"}, b1.hs, 1);
        chk({tag, " vs1"}, b1.vs, 1);
        chk({tag, " de1"}, b1.de, 0);
        chk({tag, " rgb1"}, rgb1(), 0);
        chk({tag, " fs1"}, b1.frame_start, 0);
        chk({tag, " addr1"}, b1.fb_addr, 0);
        chk({tag, " hs3"}, b3.hs, 1);
        chk({tag, " de3"}, b3.de, 0);
        chk({tag, " addr3"}, b3.fb_addr, 0);
    endtask

    // Checks and stimulus for the free-running phase, keyed by k.
    task automatic probe();
        int p1 = k - 2;
        if (p1 >= 0 && p1 < 2 * FR) begin
            if (!b1.hs) hs_lo++;
            if (!b1.vs) vs_lo++;
            if (b1.de) de_hi++;
            if (b1.frame_start) fs_cnt++;
        end
        if (b1.frame_start) begin
            if (fs_a < 0) fs_a = k;
            else if (fs_b < 0) fs_b = k;
        end
        if (b3.frame_start && fs3 < 0) fs3 = k;

        if (k >= 52 && k <= 59) begin
            chk($sformatf("addr1 v2 k%0d", k), b1.fb_addr, adr_tab[k-52]);
            chk($sformatf("addr3 v2 k%0d", k), b3.fb_addr, adr_tab[k-52]);
        end
        if (k >= 100 && k <= 107)
            chk($sformatf("addr1 v4 k%0d", k), b1.fb_addr, 4 + adr_tab[k-100]);
        if (k >= 124 && k <= 131)
            chk($sformatf("addr3 v5 k%0d", k), b3.fb_addr, 4 + adr_tab[k-124]);
        if (k == 60) chk("addr1 hold h12", b1.fb_addr, 3);
        if (k == 148) begin
            chk("addr1 hold v6", b1.fb_addr, 7);
            chk("addr3 hold v6", b3.fb_addr, 7);
        end

        if (k >= 54 && k <= 61)
            chk($sformatf("rgb1 v2 k%0d", k), rgb1(), col_tab[k-54]);
        if (k >= 56 && k <= 63)
            chk($sformatf("rgb3 v2 k%0d", k), rgb3(), col_tab[k-56]);
        if (k >= 102 && k <= 109)
            chk($sformatf("rgb1 v4 k%0d", k), rgb1(), col_tab[k-102]);
        if (k >= 104 && k <= 111)
            chk($sformatf("rgb3 v4 k%0d", k), rgb3(), col_tab[k-104]);

        if (k == 53)  chk("border1 v2h3", rgb1(), BRD);
        if (k == 55)  chk("border3 v2h3", rgb3(), BRD);
        if (k == 7)   chk("border1 v0h5", rgb1(), BRD);
        if (k == 154) chk("border1 v6h8", rgb1(), BRD);
        if (k == 66) begin
            chk("blank1 v2h16", rgb1(), 0);
            chk("de1 v2h16", b1.de, 0);
        end
        if (k == 223) chk("blank1 v9h5", rgb1(), 0);

        if (k == 19) chk("hs1 h17", b1.hs, 1);
        if (k == 20) chk("hs1 h18", b1.hs, 0);
        if (k == 22) chk("hs1 h20", b1.hs, 0);
        if (k == 23) chk("hs1 h21", b1.hs, 1);
        if (k == 21) chk("hs3 h17", b3.hs, 1);
        if (k == 24) chk("hs3 h20", b3.hs, 0);
        if (k == 25) chk("hs3 h21", b3.hs, 1);

        if (k == 217) chk("vs1 v8", b1.vs, 1);
        if (k == 218) chk("vs1 v9", b1.vs, 0);
        if (k == 265) chk("vs1 v10", b1.vs, 0);
        if (k == 266) chk("vs1 v11", b1.vs, 1);
        if (k == 220) chk("vs3 v9", b3.vs, 0);

        if (k == 17)  chk("de1 h15", b1.de, 1);
        if (k == 18)  chk("de1 h16", b1.de, 0);
        if (k == 170) chk("de1 v7", b1.de, 1);
        if (k == 194) chk("de1 v8", b1.de, 0);

        if (k == 348) chk("pal hit old", rgb1(), 16'hFFFF);
        if (k == 349) chk("pal hit new", rgb1(), 16'hF800);
        if (k == 372) chk("pal next line", rgb1(), 16'hF800);

        if (k == 347) begin
            b1.pal_we  = 1'b1;
            b1.pal_idx = 2'd3;
            b1.pal_rgb = 16'hF800;
        end
        if (k == 348) b1.pal_we = 1'b0;
    endtask

    initial begin
        rst        = 1'b0;
        b1.pal_we  = 1'b0;
        b1.pal_idx = 2'd0;
        b1.pal_rgb = 16'h0000;
        b3.pal_we  = 1'b0;
        b3.pal_idx = 2'd0;
        b3.pal_rgb = 16'h0000;

        repeat (3) @(negedge clk);
        chk_rst("reset");
        rst = 1'b1;
        k   = 0;

        while (k < 655) begin
            tick();
            probe();
        end

        chk("fs1 first", fs_a, 2);
        chk("fs1 period", fs_b - fs_a, FR);
        chk("fs3 first", fs3, 4);
        chk("fs1 pulses", fs_cnt, 2);
        chk("hs1 low count", hs_lo, 72);
        chk("vs1 low count", vs_lo, 96);
        chk("de1 high count", de_hi, 256);

        chk("pre-rst de1", b1.de, 1);
        chk("pre-rst addr1", b1.fb_addr, 1);
        rst = 1'b0;
        #1;
        chk_rst("async rst");
        @(negedge clk);
        @(negedge clk);
        chk_rst("held rst");
        rst = 1'b1;
        k   = 0;

        repeat (60) begin
            tick();
            if (k == 1) chk("restart fs1 early", b1.frame_start, 0);
            if (k == 2) begin
                chk("restart fs1", b1.frame_start, 1);
                chk("restart de1", b1.de, 1);
            end
            if (k == 3) chk("restart fs3 early", b3.frame_start, 0);
            if (k == 4) chk("restart fs3", b3.frame_start, 1);
            if (k >= 52 && k <= 59)
                chk($sformatf("restart addr1 k%0d", k), b1.fb_addr, adr_tab[k-52]);
            if (k == 59) chk("restart addr3", b3.fb_addr, 3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
